// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared instruction-word layout, fetch FSM states and buffer entry type.
package instr_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  typedef enum logic {BOOT, RUN} fetch_state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;
  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[OPCODE_LSB +: 6];
  endfunction
  function automatic logic [5:0] funct_of(input logic [INSTR_W-1:0] w);
    return w[FUNCT_LSB +: 6];
  endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry instruction FIFO with flush, push, pop and occupancy count.
module fetch_buf
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  always_comb begin
    mem_d = mem_q;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    if (push && !flush) mem_d[wr_q] = din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fixed-latency instruction fetch with redirect and a two-entry decode buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, fl_pc_q, fl_pc_d;
  logic         fl_q, fl_d;
  logic         pop, push, issue;
  logic [1:0]   count;
  fetch_entry_t head;
  // Occupancy counts the slot freed by this cycle's pop so a full pipe issues every cycle.
  always_comb begin
    pop = (count != 2'd0) && instr_ready;
    push = fl_q && !redirect_valid;
    issue = (state_q == RUN) && !redirect_valid &&
            (3'(count) - 3'(pop) + 3'(fl_q) < 3'(BUF_DEPTH));
    state_d = RUN;
    fl_d = issue;
    fl_pc_d = issue ? pc_q : fl_pc_q;
    pc_d = redirect_valid ? (redirect_pc & ~32'h3) : issue ? pc_q + 32'd4 : pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= PC_RESET;
      fl_q <= 1'b0;
      fl_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fl_q <= fl_d;
      fl_pc_q <= fl_pc_d;
    end
  end
  fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ('{instr: imem_rdata, pc: fl_pc_q}),
    .head  (head),
    .count (count)
  );
  assign imem_req = issue;
  assign imem_addr = pc_q;
  assign instr_valid = count != 2'd0;
  assign instr = head.instr;
  assign instr_pc = head.pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against a queue-based decode-stream model.
module tb_instr_fetch;
  logic        clk = 1'b0, rst = 1'b0, ready = 1'b0, redir = 1'b0;
  logic [31:0] rpc = '0, rdata0 = '0, rdata1 = '0;
  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, instr0, instr1, ipc0, ipc1;
  logic [31:0] q[$], fl[$], u1q[$];
  logic [31:0] mpc = '0;
  bit          run = 1'b0;
  int          passed = 0, total = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  always @(posedge clk) begin
    rdata0 <= req0 ? mem_f(addr0) : 32'hDEAD_BEEF;
    rdata1 <= req1 ? mem_f(addr1) : 32'hDEAD_BEEF;
  end
  instr_fetch u0 (
    .clk(clk), .rst(rst), .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .redirect_valid(redir), .redirect_pc(rpc), .instr_valid(valid0), .instr_ready(ready),
    .instr(instr0), .instr_pc(ipc0)
  );
  instr_fetch #(.PC_RESET(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .redirect_valid(redir), .redirect_pc(rpc), .instr_valid(valid1), .instr_ready(ready),
    .instr(instr1), .instr_pc(ipc1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  // One cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rp);
    bit pop, req;
    int occ;
    @(negedge clk);
    ready = r;
    redir = rv;
    rpc = rp;
    #1;
    pop = q.size() > 0 && r;
    occ = q.size() - int'(pop) + fl.size();
    req = run && !rv && occ < 2;
    chk("imem_req", 32'(req0), 32'(req));
    chk("imem_addr", addr0, mpc);
    chk("instr_valid", 32'(valid0), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("instr_pc", ipc0, q[0]);
      chk("instr", instr0, mem_f(q[0]));
    end
    if (req1 && u1q.size() < 3) u1q.push_back(addr1);
    if (rv) begin
      q.delete();
      fl.delete();
      mpc = rp & ~32'h3;
    end else begin
      if (pop) void'(q.pop_front());
      if (fl.size() > 0) q.push_back(fl.pop_front());
      if (req) begin
        fl.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    run = 1'b1;
  endtask
  task automatic do_reset();
    ready = 1'b1;
    redir = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst imem_req", 32'(req0), 32'd0);
    chk("rst imem_addr", addr0, 32'h0);
    chk("rst instr_valid", 32'(valid0), 32'd0);
    chk("rst instr", instr0, 32'h0);
    chk("rst instr_pc", ipc0, 32'h0);
    chk("rst u1 imem_addr", addr1, 32'hFFFF_FFF8);
    q.delete();
    fl.delete();
    mpc = '0;
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    logic [31:0] u1e [3];
    u1e = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    repeat (6) step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(0, 1, 32'h0000_0103);
    repeat (5) step(1, 0, 0);
    step(1, 1, 32'h0000_2000);
    repeat (4) step(1, 0, 0);
    chk("u1 request count", u1q.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("u1 wrap addr", i < u1q.size() ? u1q[i] : 32'hxxxx_xxxx, u1e[i]);
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    step(1, 0, 0);
    do_reset();
    repeat (5) step(1, 0, 0);
    do_reset();
    step(1, 1, 32'h0000_0047);
    repeat (5) step(1, 0, 0);
    repeat (200) step($urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0, $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
